// File: rtl/reg_alu_sequencer.sv
// Instruction sequencer for the reg_file_alu datapath: accepts one packed instruction,
// drives the datapath control through issue/write cycles and returns the ALU result.
module reg_alu_sequencer #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 4,
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [23:0]        instr_data,
   output logic [ADDR_W-1:0]  RA1,
   output logic [ADDR_W-1:0]  RA2,
   output logic [ADDR_W-1:0]  WA,
   output logic [DATA_W-1:0]  external_data_in,
   output logic               RegWrite,
   output logic               ALUSrc,
   output logic [1:0]         ALUControl,
   input  logic [DATA_W-1:0]  ALUResult,
   output logic               result_valid,
   input  logic               result_ready,
   output logic [DATA_W-1:0]  result_data,
   output logic [COUNT_W-1:0] instr_count
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // the producer holds its data stable while valid is high and ready is low.
   typedef enum logic [1:0] {IDLE, ISSUE, WRITE, RESP} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ra1_q, ra1_d, ra2_q, ra2_d, wa_q, wa_d;
   logic [DATA_W-1:0]   imm_q, imm_d;
   logic                src_q, src_d, we_q, we_d;
   logic [1:0]          op_q, op_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic [COUNT_W-1:0]  count_q, count_d;

   always_comb begin
      state_d  = state_q;
      ra1_d    = ra1_q;
      ra2_d    = ra2_q;
      wa_d     = wa_q;
      imm_d    = imm_q;
      src_d    = src_q;
      we_d     = we_q;
      op_d     = op_q;
      result_d = result_q;
      count_d  = count_q;
      case (state_q)
         IDLE: begin
            if (instr_valid) begin
               op_d    = instr_data[23:22];
               src_d   = instr_data[21];
               we_d    = instr_data[20];
               wa_d    = ADDR_W'(instr_data[19:16]);
               ra1_d   = ADDR_W'(instr_data[15:12]);
               ra2_d   = ADDR_W'(instr_data[11:8]);
               imm_d   = DATA_W'(instr_data[7:0]);
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = WRITE;
         WRITE: begin
            // ALUResult still reflects the pre-write register contents in this cycle.
            result_d = ALUResult;
            count_d  = count_q + COUNT_W'(1);
            state_d  = RESP;
         end
         RESP: begin
            if (result_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         ra1_q    <= '0;
         ra2_q    <= '0;
         wa_q     <= '0;
         imm_q    <= '0;
         src_q    <= 1'b0;
         we_q     <= 1'b0;
         op_q     <= 2'b00;
         result_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         ra1_q    <= ra1_d;
         ra2_q    <= ra2_d;
         wa_q     <= wa_d;
         imm_q    <= imm_d;
         src_q    <= src_d;
         we_q     <= we_d;
         op_q     <= op_d;
         result_q <= result_d;
         count_q  <= count_d;
      end
   end

   // Reset masks the strobe so an aborted instruction never writes the register file.
   assign RegWrite         = (state_q == WRITE) && we_q && !reset;
   assign instr_ready      = (state_q == IDLE);
   assign result_valid     = (state_q == RESP);
   assign RA1              = ra1_q;
   assign RA2              = ra2_q;
   assign WA               = wa_q;
   assign external_data_in = imm_q;
   assign ALUSrc           = src_q;
   assign ALUControl       = op_q;
   assign result_data      = result_q;
   assign instr_count      = count_q;

endmodule

// File: tb/tb_reg_alu_sequencer.sv
// Directed bench for reg_alu_sequencer with a small register-file/ALU model standing in
// for reg_file_alu (or a fixed stub result).
module tb_reg_alu_sequencer;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          instr_valid;
   logic          instr_ready;
   logic [23:0]   instr_data;
   logic [AW-1:0] RA1, RA2, WA;
   logic [DW-1:0] external_data_in;
   logic          RegWrite, ALUSrc;
   logic [1:0]    ALUControl;
   logic [DW-1:0] ALUResult;
   logic          result_valid, result_ready;
   logic [DW-1:0] result_data;
   logic [CW-1:0] instr_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rw_pulses = 0;
   logic          use_stub;
   logic [DW-1:0] rf [16] = '{default: 8'h00};
   logic [DW-1:0] alu_b, alu_model;
   logic [CW-1:0] exp_count;

   reg_alu_sequencer #(.DATA_W(DW), .ADDR_W(AW), .COUNT_W(CW)) dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_data(instr_data), .RA1(RA1), .RA2(RA2), .WA(WA),
      .external_data_in(external_data_in), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
      .ALUControl(ALUControl), .ALUResult(ALUResult), .result_valid(result_valid),
      .result_ready(result_ready), .result_data(result_data), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   // Datapath stand-in: op 00/01 pass operand B, 10 add, 11 subtract.
   always_comb begin
      alu_b = ALUSrc ? external_data_in : rf[RA2];
      case (ALUControl)
         2'b10:   alu_model = rf[RA1] + alu_b;
         2'b11:   alu_model = rf[RA1] - alu_b;
         default: alu_model = alu_b;
      endcase
      ALUResult = use_stub ? 8'hA5 : alu_model;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (RegWrite) rf[WA] <= ALUResult;
   end

   always @(negedge clk) if (RegWrite) rw_pulses <= rw_pulses + 1;

   function automatic logic [23:0] mk(input logic [1:0] op, input logic src, input logic we,
                                      input logic [3:0] wa, input logic [3:0] ra1,
                                      input logic [3:0] ra2, input logic [7:0] imm);
      return {op, src, we, wa, ra1, ra2, imm};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // Called at a negedge; returns at a negedge with instr_ready high or after a budget.
   task automatic wait_ready();
      int n = 0;
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ready_timeout", {31'd0, instr_ready}, 32'd1);
   endtask

   task automatic send(input logic [23:0] d);
      wait_ready();
      instr_data  = d;
      instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
   endtask

   // From just after the accepting edge through to the RESP-cycle negedge.
   task automatic run_phases(input string tag, input logic we, input logic [7:0] exp_data);
      @(negedge clk);
      check({tag, "_issue_rw"}, {31'd0, RegWrite}, 32'd0);
      check({tag, "_issue_rdy"}, {31'd0, instr_ready}, 32'd0);
      @(negedge clk);
      check({tag, "_write_rw"}, {31'd0, RegWrite}, {31'd0, we});
      check({tag, "_write_rv"}, {31'd0, result_valid}, 32'd0);
      @(negedge clk);
      exp_count = exp_count + 1'b1;
      check({tag, "_resp_rv"}, {31'd0, result_valid}, 32'd1);
      check({tag, "_resp_rw"}, {31'd0, RegWrite}, 32'd0);
      check({tag, "_data"}, {24'd0, result_data}, {24'd0, exp_data});
      check({tag, "_count"}, {28'd0, instr_count}, {28'd0, exp_count});
   endtask

   task automatic do_instr(input string tag, input logic [23:0] d, input logic [7:0] exp_data);
      send(d);
      run_phases(tag, d[20], exp_data);
      @(negedge clk);
      check({tag, "_done_rv"}, {31'd0, result_valid}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int rw0;
      int last_cyc;
      logic [7:0] held;
      reset = 1'b1; instr_valid = 1'b0; instr_data = '0; result_ready = 1'b1;
      use_stub = 1'b1; exp_count = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ra1", {28'd0, RA1}, 32'd0);
      check("rst_wa", {28'd0, WA}, 32'd0);
      check("rst_imm", {24'd0, external_data_in}, 32'd0);
      check("rst_rv", {31'd0, result_valid}, 32'd0);
      check("rst_data", {24'd0, result_data}, 32'd0);
      check("rst_count", {28'd0, instr_count}, 32'd0);
      check("rst_ready", {31'd0, instr_ready}, 32'd1);
      reset = 1'b0;
      @(negedge clk);

      // Timing with stubbed result A5: op00 src1 we1 wa5 ra1=3 ra2=4 imm 2A.
      send(mk(2'b00, 1'b1, 1'b1, 4'd5, 4'd3, 4'd4, 8'h2A));
      #1;
      check("tim_ra1", {28'd0, RA1}, 32'd3);
      check("tim_ra2", {28'd0, RA2}, 32'd4);
      check("tim_wa", {28'd0, WA}, 32'd5);
      check("tim_imm", {24'd0, external_data_in}, 32'h2A);
      check("tim_src", {31'd0, ALUSrc}, 32'd1);
      check("tim_op", {30'd0, ALUControl}, 32'd0);
      run_phases("tim", 1'b1, 8'hA5);
      @(negedge clk);

      // Reset during WRITE: strobe must drop and nothing lands in reg7.
      use_stub = 1'b0;
      send(mk(2'b10, 1'b1, 1'b1, 4'd7, 4'd1, 4'd2, 8'h33));
      @(negedge clk);
      @(negedge clk);
      check("rmid_write_rw", {31'd0, RegWrite}, 32'd1);
      reset = 1'b1;
      #1 check("rmid_rw_masked", {31'd0, RegWrite}, 32'd0);
      rw0 = rw_pulses;
      @(negedge clk);
      reset = 1'b0;
      exp_count = '0;
      check("rmid_ra1", {28'd0, RA1}, 32'd0);
      check("rmid_wa", {28'd0, WA}, 32'd0);
      check("rmid_op", {30'd0, ALUControl}, 32'd0);
      check("rmid_src", {31'd0, ALUSrc}, 32'd0);
      check("rmid_imm", {24'd0, external_data_in}, 32'd0);
      check("rmid_rv", {31'd0, result_valid}, 32'd0);
      check("rmid_data", {24'd0, result_data}, 32'd0);
      check("rmid_count", {28'd0, instr_count}, 32'd0);
      check("rmid_ready", {31'd0, instr_ready}, 32'd1);
      repeat (3) @(negedge clk);
      check("rmid_no_rw", rw_pulses - rw0, 32'd0);
      check("rmid_reg7", {24'd0, rf[7]}, 32'd0);

      // Datapath integration: load 5 and 4, then add and subtract.
      do_instr("ld5", mk(2'b01, 1'b1, 1'b1, 4'd5, 4'd0, 4'd0, 8'd5), 8'd5);
      do_instr("ld4", mk(2'b01, 1'b1, 1'b1, 4'd4, 4'd0, 4'd0, 8'd4), 8'd4);
      do_instr("add", mk(2'b10, 1'b0, 1'b0, 4'd0, 4'd5, 4'd4, 8'd0), 8'd9);
      do_instr("sub", mk(2'b11, 1'b0, 1'b0, 4'd0, 4'd5, 4'd4, 8'd0), 8'd1);

      // Backpressure: reg6 = reg5 + 0x10 = 0x15, hold result for 5 cycles.
      result_ready = 1'b0;
      rw0 = rw_pulses;
      send(mk(2'b10, 1'b1, 1'b1, 4'd6, 4'd5, 4'd0, 8'h10));
      run_phases("bp", 1'b1, 8'h15);
      held = result_data;
      instr_data  = mk(2'b11, 1'b0, 1'b1, 4'd7, 4'd6, 4'd5, 8'h00);
      instr_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_rv", {31'd0, result_valid}, 32'd1);
         check("bp_hold_data", {24'd0, result_data}, 32'h15);
         check("bp_hold_rdy", {31'd0, instr_ready}, 32'd0);
      end
      check("bp_one_rw", rw_pulses - rw0, 32'd1);
      check("bp_held", {24'd0, held}, 32'h15);
      result_ready = 1'b1;
      @(negedge clk);
      check("bp_rel_rv", {31'd0, result_valid}, 32'd0);
      check("bp_rel_rdy", {31'd0, instr_ready}, 32'd1);
      @(posedge clk);
      #1 instr_valid = 1'b0;
      check("bp_next_wa", {28'd0, WA}, 32'd7);
      run_phases("bp2", 1'b1, 8'h10);
      @(negedge clk);

      // Back-to-back: 10 loads, valid held high, one accept every 4 cycles.
      rw0 = rw_pulses;
      last_cyc = 0;
      for (int i = 0; i < 10; i++) begin
         wait_ready();
         if (i > 0) check("b2b_spacing", cyc - last_cyc, 32'd4);
         last_cyc = cyc;
         instr_data  = mk(2'b01, 1'b1, 1'b1, 4'(i), 4'd0, 4'd0, 8'(i));
         instr_valid = 1'b1;
         @(posedge clk);
         #1;
         if (i == 9) instr_valid = 1'b0;
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
      exp_count = exp_count + 4'd10;
      check("b2b_rw_pulses", rw_pulses - rw0, 32'd10);
      check("b2b_count_wrap", {28'd0, instr_count}, {28'd0, exp_count});
      check("b2b_reg9", {24'd0, rf[9]}, 32'd9);

      // Seventeenth instruction since reset: counter wraps to 1; reg9+reg9 = 18.
      do_instr("wrap", mk(2'b10, 1'b0, 1'b1, 4'd10, 4'd9, 4'd9, 8'd0), 8'd18);
      check("wrap_count", {28'd0, instr_count}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
